// File: rtl/alu_pkg.sv
// ALU operation codes shared with the ALU control decoder, plus a legality
// helper used by the execute-stage datapath.
package alu_pkg;

   localparam logic [3:0] ALU_AND  = 4'b0000;
   localparam logic [3:0] ALU_OR   = 4'b0001;
   localparam logic [3:0] ALU_ADD  = 4'b0010;
   localparam logic [3:0] ALU_SUB  = 4'b0110;
   localparam logic [3:0] ALU_SLT  = 4'b0111;
   localparam logic [3:0] ALU_XOR  = 4'b1000;
   localparam logic [3:0] ALU_SLL  = 4'b1001;
   localparam logic [3:0] ALU_SRL  = 4'b1010;
   localparam logic [3:0] ALU_SRA  = 4'b1011;
   localparam logic [3:0] ALU_SLTU = 4'b1100;

   function automatic logic is_legal_alu_code(input logic [3:0] code);
      logic legal;
      case (code)
         ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT,
         ALU_XOR, ALU_SLL, ALU_SRL, ALU_SRA, ALU_SLTU: legal = 1'b1;
         default:                                      legal = 1'b0;
      endcase
      return legal;
   endfunction

endpackage

// File: rtl/ex_alu_stage_if.sv
// Upstream/downstream signal bundle of the execute-stage ALU.
interface ex_alu_stage_if #(
   parameter int XLEN = 64
);
   logic            in_valid;
   logic            in_ready;
   logic [3:0]      alu_control;
   logic [XLEN-1:0] op_a;
   logic [XLEN-1:0] op_b;
   logic [4:0]      rd;
   logic            reg_write;
   logic            flush;
   logic            out_valid;
   logic            out_ready;
   logic [XLEN-1:0] out_result;
   logic            out_zero;
   logic [4:0]      out_rd;
   logic            out_reg_write;
   logic            out_illegal;
   logic [7:0]      illegal_count;

   modport slave (
      input  in_valid, alu_control, op_a, op_b, rd, reg_write, flush, out_ready,
      output in_ready, out_valid, out_result, out_zero, out_rd, out_reg_write,
             out_illegal, illegal_count
   );

   modport master (
      output in_valid, alu_control, op_a, op_b, rd, reg_write, flush, out_ready,
      input  in_ready, out_valid, out_result, out_zero, out_rd, out_reg_write,
             out_illegal, illegal_count
   );
endinterface

// File: rtl/ex_alu_stage_alu.sv
// Purely combinational XLEN-wide ALU datapath; illegal codes yield a zero
// result and raise the illegal flag.
module alu
   import alu_pkg::*;
#(
   parameter int XLEN = 64
) (
   input  logic [3:0]      alu_control,
   input  logic [XLEN-1:0] op_a,
   input  logic [XLEN-1:0] op_b,
   output logic [XLEN-1:0] result,
   output logic            illegal
);
   localparam int SHW = $clog2(XLEN);

   logic [SHW-1:0] w_shamt;
   logic           w_lt_signed;
   logic           w_lt_unsigned;

   // Only the low SHW bits of op_b select the shift distance.
   assign w_shamt       = op_b[SHW-1:0];
   assign w_lt_signed   = ($signed(op_a) < $signed(op_b));
   assign w_lt_unsigned = (op_a < op_b);

   always_comb begin
      result  = '0;
      illegal = !is_legal_alu_code(alu_control);
      case (alu_control)
         ALU_AND:  result = op_a & op_b;
         ALU_OR:   result = op_a | op_b;
         ALU_ADD:  result = op_a + op_b;
         ALU_SUB:  result = op_a - op_b;
         ALU_SLT:  result = {{(XLEN-1){1'b0}}, w_lt_signed};
         ALU_XOR:  result = op_a ^ op_b;
         ALU_SLL:  result = op_a << w_shamt;
         ALU_SRL:  result = op_a >> w_shamt;
         ALU_SRA:  result = $signed(op_a) >>> w_shamt;
         ALU_SLTU: result = {{(XLEN-1){1'b0}}, w_lt_unsigned};
         default:  result = '0;
      endcase
   end

endmodule

// File: rtl/ex_alu_stage.sv
// Execute-stage ALU with a one-entry valid/ready output register and a
// saturating counter of accepted illegal operation codes.
module ex_alu_stage
   import alu_pkg::*;
#(
   parameter int XLEN = 64
) (
   input  logic           clk,
   input  logic           rst_n,
   ex_alu_stage_if.slave  bus
);
   logic [XLEN-1:0] w_result;
   logic            w_illegal;
   logic            w_in_ready;
   logic            w_accept;

   logic            r_out_valid;
   logic [XLEN-1:0] r_out_result;
   logic            r_out_zero;
   logic [4:0]      r_out_rd;
   logic            r_out_reg_write;
   logic            r_out_illegal;
   logic [7:0]      r_illegal_count;

   alu #(
      .XLEN (XLEN)
   ) u_alu (
      .alu_control (bus.alu_control),
      .op_a        (bus.op_a),
      .op_b        (bus.op_b),
      .result      (w_result),
      .illegal     (w_illegal)
   );

   // in_ready looks only at the output register state, never at in_valid.
   assign w_in_ready = !r_out_valid || bus.out_ready;
   assign w_accept   = bus.in_valid && w_in_ready && !bus.flush;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_out_valid     <= 1'b0;
         r_out_result    <= '0;
         r_out_zero      <= 1'b0;
         r_out_rd        <= '0;
         r_out_reg_write <= 1'b0;
         r_out_illegal   <= 1'b0;
      end else if (bus.flush) begin
         r_out_valid <= 1'b0;
      end else if (w_accept) begin
         r_out_valid     <= 1'b1;
         r_out_result    <= w_result;
         r_out_zero      <= (w_result == '0);
         r_out_rd        <= bus.rd;
         r_out_reg_write <= bus.reg_write && !w_illegal;
         r_out_illegal   <= w_illegal;
      end else if (r_out_valid && bus.out_ready) begin
         r_out_valid <= 1'b0;
      end
   end

   // w_accept already excludes flush, so flushed inputs are never counted.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_illegal_count <= '0;
      end else if (w_accept && w_illegal && (r_illegal_count != 8'hFF)) begin
         r_illegal_count <= r_illegal_count + 8'd1;
      end
   end

   assign bus.in_ready      = w_in_ready;
   assign bus.out_valid     = r_out_valid;
   assign bus.out_result    = r_out_result;
   assign bus.out_zero      = r_out_zero;
   assign bus.out_rd        = r_out_rd;
   assign bus.out_reg_write = r_out_reg_write;
   assign bus.out_illegal   = r_out_illegal;
   assign bus.illegal_count = r_illegal_count;

endmodule
